// File: rtl/noise_detector_stream_if.sv
// Pixel stream bundle for the noise detector: input beat, output beat and their handshakes.
// The slave modport is the detector's view; the master modport is the source/sink side.
interface noise_detector_stream_if #(
  parameter int unsigned PIX_W = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pix;
  logic             in_sof;
  logic             in_eof;

  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_pix;
  logic             out_noisy;
  logic             out_salt;
  logic             out_pepper;
  logic             out_sof;
  logic             out_eof;

  modport slave (
    input  in_valid, in_pix, in_sof, in_eof, out_ready,
    output in_ready, out_valid, out_pix, out_noisy, out_salt, out_pepper, out_sof, out_eof
  );

  modport master (
    output in_valid, in_pix, in_sof, in_eof, out_ready,
    input  in_ready, out_valid, out_pix, out_noisy, out_salt, out_pepper, out_sof, out_eof
  );
endinterface

// File: rtl/noise_detector_stream.sv
// Streaming salt/pepper classifier with a one-deep valid/ready output register and a
// saturating per-frame noisy-pixel counter published at end of frame.
module noise_detector_stream #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [PIX_W-1:0]     thr_lo,
  input  logic [PIX_W-1:0]     thr_hi,
  noise_detector_stream_if.slave bus,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic                 frame_done,
  output logic                 cnt_sat
);

  localparam logic [PIX_W-1:0] PixMax = '1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_pix_q, out_pix_d;
  logic             out_salt_q, out_salt_d;
  logic             out_pepper_q, out_pepper_d;
  logic             out_sof_q, out_sof_d;
  logic             out_eof_q, out_eof_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             frame_done_q, frame_done_d;
  logic             cnt_sat_q, cnt_sat_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             run_sat_q, run_sat_d;

  logic             in_ready;
  logic             in_xfer;
  logic             pix_pepper;
  logic             pix_high;
  logic             pix_salt;
  logic [CNT_W-1:0] cnt_base;
  logic             sat_base;
  logic [CNT_W-1:0] cnt_next;
  logic             sat_next;

  assign in_ready = ~out_valid_q | bus.out_ready;
  assign in_xfer  = bus.in_valid & in_ready;

  // Pepper takes priority so an overlapping threshold band never yields both classes.
  always_comb begin
    pix_pepper = mode ? (bus.in_pix <= thr_lo) : (bus.in_pix == '0);
    pix_high   = mode ? (bus.in_pix >= thr_hi) : (bus.in_pix == PixMax);
    pix_salt   = pix_high & ~pix_pepper;
  end

  always_comb begin
    cnt_base = bus.in_sof ? '0 : run_cnt_q;
    sat_base = bus.in_sof ? 1'b0 : run_sat_q;
    cnt_next = cnt_base;
    sat_next = sat_base;
    if (pix_pepper | pix_salt) begin
      if (cnt_base == CntMax) begin
        sat_next = 1'b1;
      end else begin
        cnt_next = cnt_base + CNT_W'(1);
      end
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_pix_d    = out_pix_q;
    out_salt_d   = out_salt_q;
    out_pepper_d = out_pepper_q;
    out_sof_d    = out_sof_q;
    out_eof_d    = out_eof_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    cnt_sat_d    = cnt_sat_q;
    run_cnt_d    = run_cnt_q;
    run_sat_d    = run_sat_q;
    if (in_xfer) begin
      out_valid_d  = 1'b1;
      out_pix_d    = bus.in_pix;
      out_salt_d   = pix_salt;
      out_pepper_d = pix_pepper;
      out_sof_d    = bus.in_sof;
      out_eof_d    = bus.in_eof;
      if (bus.in_eof) begin
        frame_cnt_d  = cnt_next;
        cnt_sat_d    = sat_next;
        frame_done_d = 1'b1;
        run_cnt_d    = '0;
        run_sat_d    = 1'b0;
      end else begin
        run_cnt_d = cnt_next;
        run_sat_d = sat_next;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_pix_q    <= '0;
      out_salt_q   <= 1'b0;
      out_pepper_q <= 1'b0;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      cnt_sat_q    <= 1'b0;
      run_cnt_q    <= '0;
      run_sat_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_pix_q    <= out_pix_d;
      out_salt_q   <= out_salt_d;
      out_pepper_q <= out_pepper_d;
      out_sof_q    <= out_sof_d;
      out_eof_q    <= out_eof_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      cnt_sat_q    <= cnt_sat_d;
      run_cnt_q    <= run_cnt_d;
      run_sat_q    <= run_sat_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_pix    = out_pix_q;
  assign bus.out_salt   = out_salt_q;
  assign bus.out_pepper = out_pepper_q;
  assign bus.out_noisy  = out_salt_q | out_pepper_q;
  assign bus.out_sof    = out_sof_q;
  assign bus.out_eof    = out_eof_q;
  assign frame_cnt      = frame_cnt_q;
  assign frame_done     = frame_done_q;
  assign cnt_sat        = cnt_sat_q;

endmodule

// File: tb/tb_noise_detector_stream.sv
// Scoreboard bench for noise_detector_stream: directed frames from the test plan, then
// randomized traffic with random backpressure, checked against a frame-level model.
module tb_noise_detector_stream;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int          CntMax = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             mode = 1'b0;
  logic [PIX_W-1:0] thr_lo = '0;
  logic [PIX_W-1:0] thr_hi = '0;
  logic [CNT_W-1:0] frame_cnt;
  logic             frame_done;
  logic             cnt_sat;

  noise_detector_stream_if #(.PIX_W(PIX_W)) bus ();

  noise_detector_stream #(.PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .thr_lo    (thr_lo),
    .thr_hi    (thr_hi),
    .bus       (bus),
    .frame_cnt (frame_cnt),
    .frame_done(frame_done),
    .cnt_sat   (cnt_sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PIX_W-1:0] pix;
    logic             salt;
    logic             pep;
    logic             sof;
    logic             eof;
  } beat_t;

  beat_t sb[$];
  int    run_cnt = 0;
  int    exp_fc = 0;
  logic  exp_sat = 1'b0;
  logic  exp_done = 1'b0;
  int    total = 0;
  int    bad = 0;
  int    rr_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Classification straight from the rules: pepper dominates any overlap.
  function automatic logic [1:0] classify(input logic [PIX_W-1:0] p, input logic m,
                                          input logic [PIX_W-1:0] lo, input logic [PIX_W-1:0] hi);
    logic pep, salt;
    pep  = m ? (p <= lo) : (p == 8'h00);
    salt = (m ? (p >= hi) : (p == 8'hFF)) && !pep;
    return {salt, pep};
  endfunction

  // Model: accept whenever the output slot is free or drains this edge.
  always @(posedge clk or negedge rst_n) begin
    logic [1:0] cls;
    if (!rst_n) begin
      sb.delete();
      run_cnt  = 0;
      exp_fc   = 0;
      exp_sat  = 1'b0;
      exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (bus.in_valid && sb.size() == 0) begin
        cls = classify(bus.in_pix, mode, thr_lo, thr_hi);
        sb.push_back('{pix: bus.in_pix, salt: cls[1], pep: cls[0],
                       sof: bus.in_sof, eof: bus.in_eof});
        if (bus.in_sof) run_cnt = 0;
        if (cls != 2'b00) run_cnt++;
        if (bus.in_eof) begin
          exp_fc   = (run_cnt > CntMax) ? CntMax : run_cnt;
          exp_sat  = (run_cnt > CntMax);
          exp_done = 1'b1;
          run_cnt  = 0;
        end
      end
    end
  end

  // Monitor: compare the presented beat every cycle it is valid, pop on transfer.
  always @(negedge clk) begin
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, sb.size() != 0});
    chk("in_ready", {31'b0, bus.in_ready}, {31'b0, (sb.size() == 0) || bus.out_ready});
    chk("frame_done", {31'b0, frame_done}, {31'b0, exp_done});
    chk("frame_cnt", {28'b0, frame_cnt}, exp_fc);
    chk("cnt_sat", {31'b0, cnt_sat}, {31'b0, exp_sat});
    if (sb.size() != 0) begin
      chk("out_pix", {24'b0, bus.out_pix}, {24'b0, sb[0].pix});
      chk("out_salt", {31'b0, bus.out_salt}, {31'b0, sb[0].salt});
      chk("out_pepper", {31'b0, bus.out_pepper}, {31'b0, sb[0].pep});
      chk("out_noisy", {31'b0, bus.out_noisy}, {31'b0, sb[0].salt | sb[0].pep});
      chk("out_sof", {31'b0, bus.out_sof}, {31'b0, sb[0].sof});
      chk("out_eof", {31'b0, bus.out_eof}, {31'b0, sb[0].eof});
      if (bus.out_ready) sb.delete(0);
    end
  end

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(3) != 0);
      default: bus.out_ready = 1'b0;
    endcase
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [PIX_W-1:0] p, input logic s, input logic e);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_pix   = p;
    bus.in_sof   = s;
    bus.in_eof   = e;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_accept", {31'b0, acc}, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_pix   = '0;
    bus.in_sof   = 1'b0;
    bus.in_eof   = 1'b0;
    idle(3);
    chk("rst_frame_cnt", {28'b0, frame_cnt}, 32'd0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(1);

    // Exact extremes.
    mode = 1'b0;
    send(8'h00, 1'b1, 1'b0);
    send(8'h7F, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
    send(8'h01, 1'b0, 1'b1);
    idle(3);
    chk("mode0_frame", {28'b0, frame_cnt}, 32'd2);

    // Threshold band edges.
    mode = 1'b1; thr_lo = 8'h10; thr_hi = 8'hF0;
    send(8'h10, 1'b1, 1'b0);
    send(8'h11, 1'b0, 1'b0);
    send(8'hEF, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b1);
    idle(3);
    chk("mode1_frame", {28'b0, frame_cnt}, 32'd2);

    // Overlapping thresholds: one pixel frame, pepper only.
    thr_lo = 8'h80; thr_hi = 8'h40;
    send(8'h60, 1'b1, 1'b1);
    idle(3);
    chk("overlap_frame", {28'b0, frame_cnt}, 32'd1);

    // Backpressure: hold the output for three cycles with a pending input.
    mode = 1'b0;
    rr_mode = 2;
    idle(1);
    send(8'hFF, 1'b1, 1'b0);
    bus.in_valid = 1'b1; bus.in_pix = 8'h00; bus.in_sof = 1'b0; bus.in_eof = 1'b1;
    idle(3);
    rr_mode = 0;
    send(8'h00, 1'b0, 1'b1);
    idle(3);
    chk("stall_frame", {28'b0, frame_cnt}, 32'd2);

    // Saturation, then a clean single-pixel frame clears it.
    for (int i = 0; i < 20; i++) send(8'h00, i == 0, i == 19);
    idle(3);
    chk("sat_cnt", {28'b0, frame_cnt}, 32'd15);
    chk("sat_flag", {31'b0, cnt_sat}, 32'd1);
    send(8'h55, 1'b1, 1'b1);
    idle(3);
    chk("clean_cnt", {28'b0, frame_cnt}, 32'd0);
    chk("clean_flag", {31'b0, cnt_sat}, 32'd0);

    // Random traffic with random backpressure and config changes.
    rr_mode = 1;
    for (int i = 0; i < 400; i++) begin
      logic [PIX_W-1:0] p;
      mode   = $urandom_range(1);
      thr_lo = PIX_W'($urandom);
      thr_hi = PIX_W'($urandom);
      case ($urandom_range(3))
        0:       p = 8'h00;
        1:       p = 8'hFF;
        default: p = PIX_W'($urandom);
      endcase
      send(p, $urandom_range(7) == 0, $urandom_range(7) == 0);
      if ($urandom_range(3) == 0) idle(1);
    end

    // Reset mid-frame with a held output beat.
    rr_mode = 2;
    idle(2);
    mode = 1'b0;
    send(8'h00, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_async_cnt", {28'b0, frame_cnt}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    rr_mode = 0;
    idle(1);
    send(8'hFF, 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b1);
    idle(3);
    chk("post_rst_frame", {28'b0, frame_cnt}, 32'd2);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
